linear_layer_start_fifo_ctrl: RTL and testbench

//  Start-token FIFO between two dataflow processes of the quantised linear layer
//  (e.g. the PE_i4xi4 launch path).

---
 rtl/linear_layer_start_fifo_ctrl_if.sv | 36 +++
 rtl/linear_layer_start_fifo_ctrl.sv | 85 ++++++++
 tb/tb_linear_layer_start_fifo_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/linear_layer_start_fifo_ctrl_if.sv
// linear_layer_start_fifo_ctrl_if: producer/consumer handshake bundle for the start-token FIFO.
// LL_FIFO_ERR_EN adds the sticky overflow/underflow error outputs.
interface linear_layer_start_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_full_n;
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_empty_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
`ifdef LL_FIFO_ERR_EN
    logic                  if_ovf_err;
    logic                  if_udf_err;

    modport slave (
        output if_full_n, if_empty_n, if_dout, if_ovf_err, if_udf_err,
        input  if_write_ce, if_write, if_din, if_read_ce, if_read
    );
    modport master (
        input  if_full_n, if_empty_n, if_dout, if_ovf_err, if_udf_err,
        output if_write_ce, if_write, if_din, if_read_ce, if_read
    );
`else
    modport slave (
        output if_full_n, if_empty_n, if_dout,
        input  if_write_ce, if_write, if_din, if_read_ce, if_read
    );
    modport master (
        input  if_full_n, if_empty_n, if_dout,
        output if_write_ce, if_write, if_din, if_read_ce, if_read
    );
`endif
endinterface

// File: rtl/linear_layer_start_fifo_ctrl.sv
// linear_layer_start_fifo_ctrl: show-ahead SRL-style start-token FIFO with registered full_n/empty_n.
// Optional LL_FIFO_ERR_EN adds sticky overflow/underflow error flags.
module linear_layer_start_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    linear_layer_start_fifo_ctrl_if.slave fifo
);
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    // ptr value at count == DEPTH-1; for DEPTH=1 this is the all-ones empty pointer
    localparam logic [ADDR_WIDTH-1:0] PTR_PRE_FULL = ADDR_WIDTH'(DEPTH - 2);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_wr;
    logic                  w_rd;

    assign fifo.if_full_n  = (r_state != FULL);
    assign fifo.if_empty_n = (r_state != EMPTY);
    assign w_wr = fifo.if_write & fifo.if_write_ce & fifo.if_full_n;
    assign w_rd = fifo.if_read & fifo.if_read_ce & fifo.if_empty_n;

    always_ff @(posedge ap_clk) begin
        if (w_wr) begin
            r_mem[0] <= fifo.if_din;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < DEPTH; i++) if (r_ptr == ADDR_WIDTH'(i)) w_dout = r_mem[i];
    end

    assign fifo.if_dout = w_dout;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // simultaneous wr+rd keeps ptr: the shift moves the next-oldest entry under it
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (w_wr && !w_rd) begin
            w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
            w_state_nxt = (r_ptr == PTR_PRE_FULL) ? FULL : PARTIAL;
        end else if (!w_wr && w_rd) begin
            w_ptr_nxt   = r_ptr - ADDR_WIDTH'(1);
            w_state_nxt = (r_ptr == '0) ? EMPTY : PARTIAL;
        end
    end

`ifdef LL_FIFO_ERR_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= r_ovf_err | (fifo.if_write & fifo.if_write_ce & ~fifo.if_full_n);
            r_udf_err <= r_udf_err | (fifo.if_read & fifo.if_read_ce & ~fifo.if_empty_n);
        end
    end

    assign fifo.if_ovf_err = r_ovf_err;
    assign fifo.if_udf_err = r_udf_err;
`endif
endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// tb_linear_layer_start_fifo_ctrl: directed checks of the start-token fifo for depth 2 and depth 1
module tb_linear_layer_start_fifo_ctrl;
  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int total = 0;
  int bad = 0;
  always #5 ap_clk = ~ap_clk;
  linear_layer_start_fifo_ctrl_if #(.DATA_WIDTH(8)) f2 ();
  linear_layer_start_fifo_ctrl_if #(.DATA_WIDTH(8)) f1 ();
  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .fifo(f2)
  );
  linear_layer_start_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .fifo(f1)
  );
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    f2.if_write = w;
    f2.if_din   = d;
    f2.if_read  = r;
  endtask
  initial begin
    ap_rst_n = 1'b0;
    f2.if_write_ce = 1'b1; f2.if_read_ce = 1'b1;
    f1.if_write_ce = 1'b1; f1.if_read_ce = 1'b1;
    f1.if_write = 1'b0; f1.if_read = 1'b0; f1.if_din = 8'h00;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("rst_empty_n", f2.if_empty_n, 1'b0);
    chk("rst_full_n", f2.if_full_n, 1'b1);
`ifdef LL_FIFO_ERR_EN
    chk("rst_ovf", f2.if_ovf_err, 1'b0);
    chk("rst_udf", f2.if_udf_err, 1'b0);
`endif
    ap_rst_n = 1'b1;
    drive(1'b1, 8'hA1, 1'b0); step();
    chk("w1_empty_n", f2.if_empty_n, 1'b1);
    chk("w1_dout", f2.if_dout, 8'hA1);
    chk("w1_full_n", f2.if_full_n, 1'b1);
    drive(1'b1, 8'hB2, 1'b0); step();
    chk("w2_full_n", f2.if_full_n, 1'b0);
    chk("w2_dout", f2.if_dout, 8'hA1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("r1_dout", f2.if_dout, 8'hB2);
    chk("r1_full_n", f2.if_full_n, 1'b1);
    chk("r1_empty_n", f2.if_empty_n, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("r2_empty_n", f2.if_empty_n, 1'b0);
    chk("r2_full_n", f2.if_full_n, 1'b1);
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hC3, 1'b1); step();
    chk("rw_dout", f2.if_dout, 8'hC3);
    chk("rw_empty_n", f2.if_empty_n, 1'b1);
    chk("rw_full_n", f2.if_full_n, 1'b1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("rw_drain", f2.if_empty_n, 1'b0);
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hB2, 1'b0); step();
    chk("full_before", f2.if_full_n, 1'b0);
    drive(1'b1, 8'hD4, 1'b1); step();
    chk("full_rw_full_n", f2.if_full_n, 1'b1);
    chk("full_rw_dout", f2.if_dout, 8'hB2);
    chk("full_rw_empty_n", f2.if_empty_n, 1'b1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("full_rw_drain", f2.if_empty_n, 1'b0);
    drive(1'b1, 8'hA1, 1'b0); step();
    ap_rst_n = 1'b0;
    drive(1'b1, 8'h77, 1'b0); step();
    chk("midrst_empty_n", f2.if_empty_n, 1'b0);
    chk("midrst_full_n", f2.if_full_n, 1'b1);
    ap_rst_n = 1'b1;
    drive(1'b1, 8'h55, 1'b0); step();
    chk("postrst_dout", f2.if_dout, 8'h55);
    chk("postrst_empty_n", f2.if_empty_n, 1'b1);
    chk("postrst_full_n", f2.if_full_n, 1'b1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("postrst_drain", f2.if_empty_n, 1'b0);
    drive(1'b0, 8'h00, 1'b1); f2.if_read_ce = 1'b0; step();
    f2.if_read_ce = 1'b1;
`ifdef LL_FIFO_ERR_EN
    chk("udf_gated_by_ce", f2.if_udf_err, 1'b0);
`endif
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("udf_empty_n", f2.if_empty_n, 1'b0);
    chk("udf_full_n", f2.if_full_n, 1'b1);
`ifdef LL_FIFO_ERR_EN
    chk("udf_set", f2.if_udf_err, 1'b1);
    chk("udf_ovf_clear", f2.if_ovf_err, 1'b0);
    step();
    chk("udf_sticky", f2.if_udf_err, 1'b1);
`endif
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h33, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_full_n", f2.if_full_n, 1'b0);
    chk("ovf_dout", f2.if_dout, 8'h11);
`ifdef LL_FIFO_ERR_EN
    chk("ovf_set", f2.if_ovf_err, 1'b1);
`endif
    drive(1'b0, 8'h00, 1'b1); step();
    chk("ovf_r1_dout", f2.if_dout, 8'h22);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_drain", f2.if_empty_n, 1'b0);
`ifdef LL_FIFO_ERR_EN
    chk("ovf_sticky", f2.if_ovf_err, 1'b1);
`endif
    chk("d1_idle_empty_n", f1.if_empty_n, 1'b0);
    f1.if_write = 1'b1; f1.if_din = 8'h5A; step();
    chk("d1_w_full_n", f1.if_full_n, 1'b0);
    chk("d1_w_empty_n", f1.if_empty_n, 1'b1);
    chk("d1_w_dout", f1.if_dout, 8'h5A);
    f1.if_read = 1'b1; f1.if_din = 8'hC6; step();
    chk("d1_fullrw_empty_n", f1.if_empty_n, 1'b0);
    chk("d1_fullrw_full_n", f1.if_full_n, 1'b1);
    step();
    chk("d1_emptyrw_full_n", f1.if_full_n, 1'b0);
    chk("d1_emptyrw_dout", f1.if_dout, 8'hC6);
    f1.if_write = 1'b0; f1.if_read = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
